// File: rtl/rx_phase_sync_if.sv
// Purpose: groups the receive sample stream, enable and decision outputs of rx_phase_sync.
// Latency: none, wiring only.
// Backpressure: none, the sample stream is free-running at one sample per clock.
interface rx_phase_sync_if #(
    parameter int NB = 8,
    parameter int OS = 4
);
    localparam int PW = (OS > 1) ? $clog2(OS) : 1;

    logic                 i_enable;
    logic                 i_valid;
    logic signed [NB-1:0] i_sample;
    logic                 o_bit;
    logic                 o_bit_valid;
    logic [PW-1:0]        o_phase;
    logic                 o_locked;

    // Sample source side: drives the stream, observes decisions and lock.
    modport master (
        output i_enable, i_valid, i_sample,
        input  o_bit, o_bit_valid, o_phase, o_locked
    );

    // Phase-sync side: consumes the stream, produces decisions and lock.
    modport slave (
        input  i_enable, i_valid, i_sample,
        output o_bit, o_bit_valid, o_phase, o_locked
    );
endinterface

// File: rtl/rx_phase_sync.sv
// Purpose: picks the highest-energy sampling phase per window and slices BPSK bits there.
// Latency: decisions one clock after the selected-phase sample; phase/lock one clock after window end.
// Backpressure: none; one sample per clock, i_valid marks phase 0 of every symbol.
module rx_phase_sync #(
    parameter int NB       = 8,
    parameter int OS       = 4,
    parameter int WIN_LOG2 = 10,
    parameter int NB_ACC   = 18
) (
    input  logic        clock,
    input  logic        i_reset,
    rx_phase_sync_if.slave bus
);
    localparam int PW = (OS > 1) ? $clog2(OS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACQ   = 2'd1,
        ST_TRACK = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       ph_q, ph_d;
    logic [PW-1:0]       phase_q, phase_d;
    logic [WIN_LOG2-1:0] sym_cnt_q, sym_cnt_d;
    logic [NB_ACC-1:0]   acc_q [OS];
    logic [NB_ACC-1:0]   acc_d [OS];
    logic                bit_q, bit_d;
    logic                bit_vld_q, bit_vld_d;

    logic [NB-1:0]       raw;
    logic [NB-1:0]       mag;
    logic [NB_ACC:0]     sum;
    logic [NB_ACC-1:0]   acc_new;
    logic [NB_ACC-1:0]   mag_ext;
    logic [PW-1:0]       best_idx;
    logic [NB_ACC-1:0]   best_val;
    logic                win_end;

    // Phase of the current sample, its magnitude and the saturating accumulate into that phase.
    always_comb begin
        ph_d    = bus.i_valid ? '0 : ph_q + PW'(1);
        raw     = bus.i_sample;
        // Two's-complement negate; -2^(NB-1) lands on 2^(NB-1) as unsigned, which fits.
        mag     = raw[NB-1] ? (~raw + NB'(1)) : raw;
        mag_ext = NB_ACC'(mag);
        sum     = {1'b0, acc_q[ph_d]} + (NB_ACC+1)'(mag);
        acc_new = sum[NB_ACC] ? '1 : sum[NB_ACC-1:0];
        win_end = bus.i_valid && (&sym_cnt_q);
    end

    // Argmax over the accumulators; strict compare keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_val = acc_q[0];
        for (int i = 1; i < OS; i++) begin
            if (acc_q[i] > best_val) begin
                best_val = acc_q[i];
                best_idx = PW'(i);
            end
        end
    end

    // Next-state logic: window bookkeeping, phase selection and bit decision.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        sym_cnt_d = sym_cnt_q;
        bit_d     = bit_q;
        bit_vld_d = 1'b0;
        for (int i = 0; i < OS; i++) acc_d[i] = acc_q[i];

        if (state_q != ST_IDLE && ph_d == phase_q) begin
            bit_d     = bus.i_sample[NB-1];
            bit_vld_d = 1'b1;
        end

        if (!bus.i_enable) begin
            // Partial window is thrown away; the selected phase is kept for the next run.
            state_d   = ST_IDLE;
            sym_cnt_d = '0;
            for (int i = 0; i < OS; i++) acc_d[i] = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sym_cnt_d = '0;
                    for (int i = 0; i < OS; i++) acc_d[i] = '0;
                    if (bus.i_valid) begin
                        // The entering strobe's sample opens the first window.
                        state_d  = ST_ACQ;
                        acc_d[0] = mag_ext;
                    end
                end
                ST_ACQ, ST_TRACK: begin
                    if (win_end) begin
                        phase_d   = best_idx;
                        state_d   = ST_TRACK;
                        sym_cnt_d = '0;
                        for (int i = 0; i < OS; i++) acc_d[i] = '0;
                        acc_d[ph_d] = mag_ext;
                    end else begin
                        if (bus.i_valid) sym_cnt_d = sym_cnt_q + WIN_LOG2'(1);
                        acc_d[ph_d] = acc_new;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= ST_IDLE;
            ph_q      <= '0;
            phase_q   <= '0;
            sym_cnt_q <= '0;
            bit_q     <= 1'b0;
            bit_vld_q <= 1'b0;
            for (int i = 0; i < OS; i++) acc_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            phase_q   <= phase_d;
            sym_cnt_q <= sym_cnt_d;
            bit_q     <= bit_d;
            bit_vld_q <= bit_vld_d;
            for (int i = 0; i < OS; i++) acc_q[i] <= acc_d[i];
        end
    end

    assign bus.o_bit       = bit_q;
    assign bus.o_bit_valid = bit_vld_q;
    assign bus.o_phase     = phase_q;
    assign bus.o_locked    = (state_q == ST_TRACK);
endmodule

// File: tb/tb_rx_phase_sync.sv
// Purpose: checks rx_phase_sync against a window-level energy model, full and narrow accumulators.
// Latency: outputs compared on the falling edge after each rising edge.
// Backpressure: none; the bench drives one sample per clock.
module tb_rx_phase_sync;
    localparam int     NB        = 8;
    localparam int     OS        = 4;
    localparam int     WIN       = 1024;
    localparam longint MAX_MAIN  = (64'd1 << 18) - 1;
    localparam longint MAX_SAT   = (64'd1 << 12) - 1;

    logic clock = 1'b0;
    logic i_reset;
    always #5 clock = ~clock;

    rx_phase_sync_if #(.NB(NB), .OS(OS)) bus ();
    rx_phase_sync_if #(.NB(NB), .OS(OS)) sat_bus ();

    assign sat_bus.i_enable = bus.i_enable;
    assign sat_bus.i_valid  = bus.i_valid;
    assign sat_bus.i_sample = bus.i_sample;

    rx_phase_sync #(.NB(NB), .OS(OS), .WIN_LOG2(10), .NB_ACC(18)) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    rx_phase_sync #(.NB(NB), .OS(OS), .WIN_LOG2(10), .NB_ACC(12)) dut_sat (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (sat_bus)
    );

    int checks = 0;
    int errors = 0;
    bit en;

    // Reference model: symbol-level window of per-phase magnitude sums.
    bit     m_active, m_locked, exp_bit, exp_bv;
    int     m_phase, m_phase_s, m_ph, m_count;
    longint sums [OS];

    function automatic int pick(input longint lim);
        longint best = -1;
        int     idx  = 0;
        for (int i = 0; i < OS; i++) begin
            longint v = (sums[i] > lim) ? lim : sums[i];
            if (v > best) begin
                best = v;
                idx  = i;
            end
        end
        return idx;
    endfunction

    task automatic model_reset();
        m_active = 0; m_locked = 0; exp_bit = 0; exp_bv = 0;
        m_phase = 0; m_phase_s = 0; m_ph = 0; m_count = 0;
        for (int i = 0; i < OS; i++) sums[i] = 0;
    endtask

    task automatic model_clock(input bit v, input logic signed [NB-1:0] s);
        int sv = s;
        int mg = (sv < 0) ? -sv : sv;
        m_ph = v ? 0 : (m_ph + 1) % OS;
        if (m_active && m_ph == m_phase) begin
            exp_bv  = 1;
            exp_bit = (sv < 0);
        end else begin
            exp_bv = 0;
        end
        if (!en) begin
            m_active = 0; m_locked = 0; m_count = 0;
            for (int i = 0; i < OS; i++) sums[i] = 0;
        end else if (!m_active) begin
            if (v) begin
                m_active = 1; m_count = 1;
                for (int i = 0; i < OS; i++) sums[i] = 0;
                sums[0] = mg;
            end
        end else begin
            if (v && m_count == WIN) begin
                m_phase   = pick(MAX_MAIN);
                m_phase_s = pick(MAX_SAT);
                m_locked  = 1;
                m_count   = 1;
                for (int i = 0; i < OS; i++) sums[i] = 0;
            end else if (v) begin
                m_count++;
            end
            sums[m_ph] += mg;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("o_bit_valid", 32'(bus.o_bit_valid), 32'(exp_bv));
        chk("o_bit",       32'(bus.o_bit),       32'(exp_bit));
        chk("o_phase",     32'(bus.o_phase),     32'(m_phase));
        chk("o_locked",    32'(bus.o_locked),    32'(m_locked));
        chk("sat_o_phase", 32'(sat_bus.o_phase), 32'(m_phase_s));
        chk("sat_locked",  32'(sat_bus.o_locked), 32'(m_locked));
    endtask

    // One clock: drive at the falling edge, model at the rising edge, compare at the next falling edge.
    task automatic step(input bit v, input logic signed [NB-1:0] s);
        bus.i_valid  = v;
        bus.i_sample = s;
        bus.i_enable = en;
        @(posedge clock);
        if (!i_reset) model_reset();
        else          model_clock(v, s);
        @(negedge clock);
        check_all();
    endtask

    task automatic run_symbols(input int n, input int m0, input int m1, input int m2, input int m3,
                               input bit force_neg, input int noise,
                               input int exp_ph, input int exp_ph_s);
        int mags [OS];
        mags[0] = m0; mags[1] = m1; mags[2] = m2; mags[3] = m3;
        for (int k = 0; k < n; k++) begin
            for (int p = 0; p < OS; p++) begin
                bit neg = force_neg ? 1'b1 : 1'($urandom % 2);
                int mg  = mags[p] + ((noise > 0) ? int'($urandom_range(0, noise)) : 0);
                if (!neg && mg > 127) mg = 127;
                step(p == 0, NB'(neg ? -mg : mg));
                if (k == 0 && p == 0 && exp_ph >= 0) begin
                    chk("window_pick",     32'(bus.o_phase),     32'(exp_ph));
                    chk("window_locked",   32'(bus.o_locked),    32'd1);
                    chk("window_sat_pick", 32'(sat_bus.o_phase), 32'(exp_ph_s));
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        en           = 0;
        bus.i_enable = 0;
        bus.i_valid  = 0;
        bus.i_sample = '0;
        i_reset      = 0;
        model_reset();
        @(negedge clock);

        // Reset held with random input traffic.
        for (int i = 0; i < 8; i++) step(($urandom % 4) == 0, NB'($urandom));
        chk("reset_bit",    32'(bus.o_bit),    32'd0);
        chk("reset_phase",  32'(bus.o_phase),  32'd0);
        chk("reset_locked", 32'(bus.o_locked), 32'd0);

        // Released but disabled: no decisions, no lock.
        i_reset = 1;
        run_symbols(10, 30, 30, 30, 30, 0, 5, -1, -1);

        en = 1;
        run_symbols(WIN, 10, 40, 100, 40, 0, 5, -1, -1);
        run_symbols(WIN, 10, 100, 40, 20, 0, 5, 2, 0);
        run_symbols(WIN, 50, 50, 50, 50, 0, 0, 1, 0);
        run_symbols(WIN, 128, 128, 128, 128, 1, 0, 0, 0);
        run_symbols(WIN, 3, 50, 127, 4, 0, 0, 0, 0);
        run_symbols(500, 5, 10, 20, 60, 0, 3, 2, 1);

        // Disable mid-window: lock drops, phase kept, a full new window is needed.
        en = 0;
        run_symbols(3, 5, 10, 20, 60, 0, 3, -1, -1);
        chk("disable_locked", 32'(bus.o_locked), 32'd0);
        chk("disable_phase",  32'(bus.o_phase),  32'd2);
        en = 1;
        run_symbols(WIN, 5, 10, 20, 60, 0, 3, -1, -1);
        chk("relock_not_early", 32'(bus.o_locked), 32'd0);
        run_symbols(500, 2, 3, 1, 60, 0, 0, 3, 0);

        // Asynchronous reset mid-window takes effect without a clock edge.
        i_reset = 0;
        #1;
        chk("async_rst_bit",    32'(bus.o_bit),       32'd0);
        chk("async_rst_bv",     32'(bus.o_bit_valid), 32'd0);
        chk("async_rst_phase",  32'(bus.o_phase),     32'd0);
        chk("async_rst_locked", 32'(bus.o_locked),    32'd0);
        model_reset();
        run_symbols(2, 2, 3, 1, 60, 0, 0, -1, -1);
        i_reset = 1;
        run_symbols(WIN, 2, 3, 1, 60, 0, 0, -1, -1);
        chk("reset_relock_not_early", 32'(bus.o_locked), 32'd0);
        run_symbols(4, 2, 3, 1, 60, 0, 0, 3, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rx_phase_sync.md
# rx_phase_sync

Receive-side symbol-timing block for the PRBS9/BPSK/RC link. It takes the oversampled RC filter output (OS samples per symbol) and measures the mean magnitude at each sampling phase over a fixed window of symbols. It then selects the phase with the largest energy and emits a hard-decision bit stream at that phase. It replaces the manual switch-selected sampling offset ahead of the BER checker and reports lock status for an LED.

## Interface
- NB, 8, width of signed input sample
- OS, 4, oversampling factor; power of 2, ≥2
- WIN_LOG2, 10, log2 of symbols per measurement window (1024)
- NB_ACC, 18, per-phase accumulator width; must be ≥ NB+WIN_LOG2

- clock  in  1  system clock
- i_reset  in  1  reset, asynchronous, active-low
- i_enable  in  1  RX enable; low forces IDLE
- i_valid  in  1  symbol strobe, one clock every OS clocks; marks phase 0
- i_sample  in  NB  signed filter output, one per clock
- o_bit  out  1  hard decision, sign bit of selected sample (neg = 1)
- o_bit_valid  out  1  one-clock strobe qualifying o_bit
- o_phase  out  $clog2(OS)  currently selected sampling phase
- o_locked  out  1  high once at least one full window has been evaluated

## Operation
- Phase counter ph: loads 0 on any clock with i_valid=1; otherwise increments modulo OS. Free-running, including while disabled.
- Magnitude: |i_sample| as NB-bit unsigned. The most-negative input (−2^(NB−1)) maps to 2^(NB−1). No saturation is needed.
- Accumulators acc[0..OS-1]: in ACQUIRE/TRACK, acc[ph] += magnitude every clock. Each accumulator saturates at 2^NB_ACC−1 and does not wrap.
- Symbol counter sym_cnt (WIN_LOG2 bits): increments on each i_valid in ACQUIRE/TRACK.
- Window end: i_valid arrives with sym_cnt = 2^WIN_LOG2−1.
  - Evaluate the maximum over acc[] as it stands before this clock's sample. On a tie, the lowest index wins.
  - The winning index is registered into o_phase.
  - All accumulators clear, and this clock's sample is the first sample of the new window.
  - sym_cnt wraps to 0.
- FSM:
  - IDLE: accumulators and sym_cnt held at 0; o_locked=0; o_phase holds its last value. Moves to ACQUIRE on the first i_valid with i_enable=1. Accumulation starts with that sample.
  - ACQUIRE: accumulate; o_locked=0. At window end, moves to TRACK.
  - TRACK: accumulate; o_locked=1. At each window end, o_phase is re-evaluated, and may change.
  - Any state: i_enable=0 moves to IDLE on the next clock. Any partial window is discarded.
- Decision: on each clock with ph == o_phase and state ≠ IDLE, o_bit ← i_sample[NB-1] and o_bit_valid ← 1. Otherwise o_bit_valid ← 0 and o_bit holds.
- Exactly one o_bit_valid per symbol in steady state. When o_phase changes at a window end, one symbol may be skipped or duplicated; this is acceptable, and the downstream BER sync re-aligns.

## Timing
- Reset (i_reset=0, async): o_bit=0, o_bit_valid=0, o_phase=0, o_locked=0, state IDLE, ph=0, all accumulators and sym_cnt at 0.
- Decision latency: o_bit/o_bit_valid are registered one clock after the selected-phase sample is presented.
- o_phase and o_locked update one clock after the window-end i_valid clock. Decisions start using the new phase from the following clock.
- First lock: 2^WIN_LOG2 symbol strobes after entering ACQUIRE, plus 1 clock.
- Reset asserted mid-window returns everything to reset values immediately. After release, acquisition restarts on the next enabled i_valid.
- i_enable is sampled synchronously. No clock-gating; the block is active only when i_enable=1 and i_reset=1.

## Test plan
- Reset: hold i_reset=0 with random i_sample → all outputs 0. Release with i_enable=0 → o_bit_valid stays 0 and o_locked stays 0.
- Phase pick: drive OS=4 with magnitudes {10,40,100,40} at phases 0..3, signs from PRBS9, i_enable=1 → after 1024 i_valid strobes +1 clock, o_phase=2 and o_locked=1. o_bit then matches the PRBS9 sign at phase 2, one clock late, with one strobe per 4 clocks.
- Tie: equal magnitude 50 at all phases → o_phase=0 at window end.
- Re-track: after lock on phase 2, move the peak to phase 1 → at the next window end o_phase=1, and o_locked stays 1 throughout.
- Boundary and saturation:
  - Constant −128 input with NB_ACC=NB+WIN_LOG2 → accumulators reach 131072 without wrap, and the pick is phase 0.
  - Constant −128 input with NB_ACC reduced to 12 → the accumulator clamps at 4095.
- Disable/reset mid-window: drop i_enable at symbol 500 → next clock IDLE, o_locked=0, o_phase unchanged. Re-enable → lock only after a further 1024 strobes. Repeat with i_reset=0 at symbol 500 → immediate reset values.
